dlfloat_operand_sequencer: RTL and testbench

Upstream operand-staging stage for the DLFloat MAC datapath. Accepts a stream of 16-bit DLFloat words (A then B, alternating), pairs them, and buffers the pairs in a small FIFO. It presents each pair to the MAC with a valid/ready handshake, tagged with an accumulator-clear flag. It also keeps a per-accumulation pair count and a sticky NaN (16'hFFFF) flag.

---
 rtl/dlfloat_operand_sequencer.sv | 120 ++++++++++++
 tb/tb_dlfloat_operand_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_operand_sequencer.sv
// DLFloat operand sequencer: pairs an A/B word stream, stages the pairs in a
// small show-ahead FIFO and presents them to the MAC with a clear tag, a
// per-accumulation pair count and a sticky NaN (16'hFFFF) flag.
module dlfloat_operand_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        cmd_clr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic        out_clr,
    output logic [7:0]  pair_count,
    output logic        err_nan
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {WAIT_A, WAIT_B} state_t;

    state_t          state, state_nxt;
    logic [15:0]     a_q;
    logic            clr_pend;
    logic [32:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [32:0]     head;
    logic            full, accept, push, pop, push_clr, push_nan;

    // Full uses the registered occupancy, so a same-cycle pop never frees a slot early.
    assign full     = (count == CW'(DEPTH));
    assign accept   = in_valid & in_ready;
    assign push     = accept & (state == WAIT_B) & ~flush;
    assign pop      = out_valid & out_ready & ~flush;
    assign push_clr = clr_pend | cmd_clr;
    assign push_nan = push & ((a_q == 16'hFFFF) | (in_data == 16'hFFFF));

    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_a     = out_valid ? head[32:17] : 16'h0000;
    assign out_b     = out_valid ? head[16:1]  : 16'h0000;
    assign out_clr   = out_valid & head[0];

    // Pairing FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_A;
        else        state <= state_nxt;
    end

    // Pairing FSM next state and input-side ready.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == WAIT_A) | ~full;
        if (flush)
            state_nxt = WAIT_A;
        else if (accept)
            state_nxt = (state == WAIT_A) ? WAIT_B : WAIT_A;
    end

    // A-word hold register and pending-clear flag for the next pushed pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= 16'h0000;
            clr_pend <= 1'b0;
        end else if (flush) begin
            clr_pend <= 1'b0;
        end else begin
            if (accept && state == WAIT_A) a_q <= in_data;
            if (push)         clr_pend <= 1'b0;
            else if (cmd_clr) clr_pend <= 1'b1;
        end
    end

    // Pair storage; data only, validity is tracked by the occupancy counter.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {a_q, in_data, push_clr};
    end

    // FIFO pointers and occupancy; flush empties everything on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Pair count restarts at 1 on a clr-tagged pop, else saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pair_count <= 8'd0;
        else if (pop) begin
            if (head[0])                  pair_count <= 8'd1;
            else if (pair_count != 8'hFF) pair_count <= pair_count + 8'd1;
        end
    end

    // Sticky NaN flag; a NaN push in the same cycle as cmd_clr keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          err_nan <= 1'b0;
        else if (flush)      err_nan <= err_nan;
        else if (push_nan)   err_nan <= 1'b1;
        else if (cmd_clr)    err_nan <= 1'b0;
    end
endmodule

// File: tb/tb_dlfloat_operand_sequencer.sv
// Table-driven bench for dlfloat_operand_sequencer (DEPTH=4).
// Each row: inputs driven for one cycle plus the outputs expected in that
// cycle before the next rising edge.
module tb_dlfloat_operand_sequencer;
    logic        clk, rst_n;
    logic        in_valid, in_ready, cmd_clr, flush;
    logic [15:0] in_data;
    logic        out_valid, out_ready, out_clr, err_nan;
    logic [15:0] out_a, out_b;
    logic [7:0]  pair_count;

    int checks = 0;
    int errors = 0;

    dlfloat_operand_sequencer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cmd_clr(cmd_clr), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_clr(out_clr),
        .pair_count(pair_count), .err_nan(err_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        c, f, r;
        logic        e_irdy, e_ov;
        logic [15:0] e_a, e_b;
        logic        e_oc;
        logic [7:0]  e_pc;
        logic        e_nan;
    } vec_t;

    vec_t tbl [128];
    int   n = 0;

    task automatic add(input logic v, input logic [15:0] d, input logic c, input logic f,
                       input logic r, input logic ir, input logic ov, input logic [15:0] a,
                       input logic [15:0] b, input logic oc, input logic [7:0] pc,
                       input logic nan);
        tbl[n] = '{v, d, c, f, r, ir, ov, a, b, oc, pc, nan};
        n++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; cmd_clr = 1'b0;
        flush = 1'b0; out_ready = 1'b0;

        // single pair
        add(1,16'h3E00,0,0,1, 1,0,16'h0,16'h0,0,8'd0,0);
        add(1,16'h4000,0,0,1, 1,0,16'h0,16'h0,0,8'd0,0);
        add(0,16'h0,0,0,1,    1,1,16'h3E00,16'h4000,0,8'd0,0);
        add(0,16'h0,0,0,1,    1,0,16'h0,16'h0,0,8'd1,0);
        // backpressure until full, then drain
        for (int k = 1; k <= 4; k++) begin
            add(1,16'(k*256+1),0,0,0, 1,k>1, k>1?16'h0101:16'h0, k>1?16'h0102:16'h0,0,8'd1,0);
            add(1,16'(k*256+2),0,0,0, 1,k>1, k>1?16'h0101:16'h0, k>1?16'h0102:16'h0,0,8'd1,0);
        end
        add(1,16'h0501,0,0,0, 1,1,16'h0101,16'h0102,0,8'd1,0);
        add(1,16'h0502,0,0,1, 0,1,16'h0101,16'h0102,0,8'd1,0);
        add(1,16'h0502,0,0,1, 1,1,16'h0201,16'h0202,0,8'd2,0);
        add(0,16'h0,0,0,1,    1,1,16'h0301,16'h0302,0,8'd3,0);
        add(0,16'h0,0,0,1,    1,1,16'h0401,16'h0402,0,8'd4,0);
        add(0,16'h0,0,0,1,    1,1,16'h0501,16'h0502,0,8'd5,0);
        add(0,16'h0,0,0,1,    1,0,16'h0,16'h0,0,8'd6,0);
        // clear tagging on the B word of pair 3
        add(1,16'h0A01,0,0,1, 1,0,16'h0,16'h0,0,8'd6,0);
        add(1,16'h0A02,0,0,1, 1,0,16'h0,16'h0,0,8'd6,0);
        add(1,16'h0B01,0,0,1, 1,1,16'h0A01,16'h0A02,0,8'd6,0);
        add(1,16'h0B02,0,0,1, 1,0,16'h0,16'h0,0,8'd7,0);
        add(1,16'h0C01,0,0,1, 1,1,16'h0B01,16'h0B02,0,8'd7,0);
        add(1,16'h0C02,1,0,1, 1,0,16'h0,16'h0,0,8'd8,0);
        add(1,16'h0D01,0,0,1, 1,1,16'h0C01,16'h0C02,1,8'd8,0);
        add(1,16'h0D02,0,0,1, 1,0,16'h0,16'h0,0,8'd1,0);
        add(0,16'h0,0,0,1,    1,1,16'h0D01,16'h0D02,0,8'd1,0);
        add(0,16'h0,0,0,1,    1,0,16'h0,16'h0,0,8'd2,0);
        // NaN sticky, zero passthrough, clear while idle tags next pair
        add(1,16'hFFFF,0,0,1, 1,0,16'h0,16'h0,0,8'd2,0);
        add(1,16'h3E00,0,0,1, 1,0,16'h0,16'h0,0,8'd2,0);
        add(1,16'h0001,0,0,1, 1,1,16'hFFFF,16'h3E00,0,8'd2,1);
        add(1,16'h0000,0,0,1, 1,0,16'h0,16'h0,0,8'd3,1);
        add(0,16'h0,0,0,1,    1,1,16'h0001,16'h0000,0,8'd3,1);
        add(0,16'h0,1,0,1,    1,0,16'h0,16'h0,0,8'd4,1);
        add(1,16'h1111,0,0,1, 1,0,16'h0,16'h0,0,8'd4,0);
        add(1,16'h2222,0,0,1, 1,0,16'h0,16'h0,0,8'd4,0);
        add(0,16'h0,0,0,1,    1,1,16'h1111,16'h2222,1,8'd4,0);
        add(0,16'h0,0,0,1,    1,0,16'h0,16'h0,0,8'd1,0);
        // flush with a half pair held, then stream across the pointer wrap
        add(1,16'hE001,0,0,0, 1,0,16'h0,16'h0,0,8'd1,0);
        add(1,16'hE002,0,0,0, 1,0,16'h0,16'h0,0,8'd1,0);
        add(1,16'hE101,0,0,0, 1,1,16'hE001,16'hE002,0,8'd1,0);
        add(1,16'hE102,0,0,0, 1,1,16'hE001,16'hE002,0,8'd1,0);
        add(1,16'hE201,0,0,0, 1,1,16'hE001,16'hE002,0,8'd1,0);
        add(1,16'hE202,0,0,0, 1,1,16'hE001,16'hE002,0,8'd1,0);
        add(1,16'hE301,0,0,1, 1,1,16'hE001,16'hE002,0,8'd1,0);
        add(0,16'h0,0,1,1,    1,1,16'hE101,16'hE102,0,8'd2,0);
        add(0,16'h0,0,0,1,    1,0,16'h0,16'h0,0,8'd2,0);
        for (int k = 0; k < 6; k++) begin
            add(1,16'(16'hF001+k*256),0,0,1, 1,k>0,
                k>0?16'(16'hF001+(k-1)*256):16'h0, k>0?16'(16'hF002+(k-1)*256):16'h0,
                0, (k==0)?8'd2:8'(1+k), 0);
            add(1,16'(16'hF002+k*256),0,0,1, 1,0,16'h0,16'h0,0,8'(2+k),0);
        end
        add(0,16'h0,0,0,1, 1,1,16'hF501,16'hF502,0,8'd7,0);
        add(0,16'h0,0,0,1, 1,0,16'h0,16'h0,0,8'd8,0);

        // reset state
        #1;
        chk("rst in_ready",   32'(in_ready),   32'd1);
        chk("rst out_valid",  32'(out_valid),  32'd0);
        chk("rst out_a",      32'(out_a),      32'd0);
        chk("rst out_b",      32'(out_b),      32'd0);
        chk("rst out_clr",    32'(out_clr),    32'd0);
        chk("rst pair_count", 32'(pair_count), 32'd0);
        chk("rst err_nan",    32'(err_nan),    32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = tbl[i].v; in_data = tbl[i].d; cmd_clr = tbl[i].c;
            flush = tbl[i].f; out_ready = tbl[i].r;
            #1;
            chk($sformatf("row%0d in_ready", i),   32'(in_ready),   32'(tbl[i].e_irdy));
            chk($sformatf("row%0d out_valid", i),  32'(out_valid),  32'(tbl[i].e_ov));
            chk($sformatf("row%0d out_a", i),      32'(out_a),      32'(tbl[i].e_a));
            chk($sformatf("row%0d out_b", i),      32'(out_b),      32'(tbl[i].e_b));
            chk($sformatf("row%0d out_clr", i),    32'(out_clr),    32'(tbl[i].e_oc));
            chk($sformatf("row%0d pair_count", i), 32'(pair_count), 32'(tbl[i].e_pc));
            chk($sformatf("row%0d err_nan", i),    32'(err_nan),    32'(tbl[i].e_nan));
        end
        @(negedge clk);
        in_valid = 1'b0; cmd_clr = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // reset mid-stream: fill FIFO (first pair has a NaN B), hold A=AAAA in a_q
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 16'(16'hC001 + k*256);
            @(negedge clk); in_data = (k == 0) ? 16'hFFFF : 16'(16'hC002 + k*256);
        end
        @(negedge clk); in_data = 16'hAAAA;
        @(negedge clk); in_valid = 1'b0;
        #1;
        chk("full in_ready",  32'(in_ready),  32'd0);
        chk("full out_valid", 32'(out_valid), 32'd1);
        chk("full out_a",     32'(out_a),     32'hC001);
        chk("full out_b",     32'(out_b),     32'hFFFF);
        chk("full err_nan",   32'(err_nan),   32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst in_ready",   32'(in_ready),   32'd1);
        chk("arst out_valid",  32'(out_valid),  32'd0);
        chk("arst out_a",      32'(out_a),      32'd0);
        chk("arst out_b",      32'(out_b),      32'd0);
        chk("arst pair_count", 32'(pair_count), 32'd0);
        chk("arst err_nan",    32'(err_nan),    32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); in_valid = 1'b1; in_data = 16'h1234;
        @(negedge clk); in_data = 16'h5678;
        @(negedge clk); in_valid = 1'b0;
        #1;
        chk("post out_valid",  32'(out_valid),  32'd1);
        chk("post out_a",      32'(out_a),      32'h1234);
        chk("post out_b",      32'(out_b),      32'h5678);
        chk("post out_clr",    32'(out_clr),    32'd0);
        chk("post pair_count", 32'(pair_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
